// File: rtl/multiplication_mod_if.sv
// Operand/result/Stall bundle shared with the divider so the ALU stage can
// steer either arithmetic unit through the same port group.
interface multiplication_mod_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] A2;
   logic [WIDTH-1:0] B1;
   logic [WIDTH-1:0] B2;
   logic [3:0]       Op;
   logic [WIDTH-1:0] Out1;
   logic [WIDTH-1:0] Out2;
   logic             Stall;

   modport master (
      output A1, A2, B1, B2, Op,
      input  Out1, Out2, Stall
   );

   modport slave (
      input  A1, A2, B1, B2, Op,
      output Out1, Out2, Stall
   );
endinterface

// File: rtl/multiplication_mod.sv
// Multicycle unsigned shift-add multiplier / multiply-add (IDLE->BUSY->DONE).
// Optional MULTIPLICATION_MOD_EARLY_EXIT_EN leaves BUSY once the multiplier runs out of ones.
module multiplication_mod #(
   parameter int         WIDTH     = 8,
   parameter logic [3:0] OP_MUL    = 4'b0010,
   parameter logic [3:0] OP_MULADD = 4'b0101
) (
   input  logic                clk,
   input  logic                rst,
   multiplication_mod_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_addend;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_out;

   logic             w_is_mul;
   logic             w_last;
   logic [PW-1:0]    w_pp;

   assign w_is_mul = (bus.Op == OP_MUL) || (bus.Op == OP_MULADD);
   assign w_pp     = r_mplier[0] ? (r_mcand << r_cnt) : '0;

`ifdef MULTIPLICATION_MOD_EARLY_EXIT_EN
   // No ones left above the current bit: remaining iterations would add nothing.
   assign w_last = (r_cnt == CW'(WIDTH - 1)) || ((r_mplier >> 1) == '0);
`else
   assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_addend <= '0;
         r_cnt    <= '0;
         r_out    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mul) begin
                  r_mcand  <= {{WIDTH{1'b0}}, bus.A1};
                  r_mplier <= bus.B1;
                  r_addend <= (bus.Op == OP_MULADD) ? {bus.B2, bus.A2} : '0;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= r_acc + w_pp;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               // Carry out of the multiply-add is dropped (mod 2^PW).
               r_out   <= r_acc + r_addend;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.Stall = ((r_state == S_IDLE) && w_is_mul) || (r_state == S_BUSY);
   assign bus.Out1  = r_out[PW-1:WIDTH];
   assign bus.Out2  = r_out[WIDTH-1:0];

endmodule

// File: tb/tb_multiplication_mod.sv
// Scoreboard bench for multiplication_mod: stimulus pushes expected results,
// a negedge monitor pops them when Stall falls and checks latency and outputs.
module tb_multiplication_mod;
   localparam int         W         = 8;
   localparam logic [3:0] OP_MUL    = 4'b0010;
   localparam logic [3:0] OP_MULADD = 4'b0101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multiplication_mod_if #(.WIDTH(W)) mif();
   multiplication_mod #(.WIDTH(W), .OP_MUL(OP_MUL), .OP_MULADD(OP_MULADD)) dut (
      .clk(clk),
      .rst(rst),
      .bus(mif)
   );

   typedef struct {
      logic [31:0] res;
      logic [31:0] ncyc;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] last_out = 0;
   int          last_gap = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Stall duration: capture cycle plus BUSY cycles (bit length of B1 when exiting early).
   function automatic logic [31:0] stall_len(input logic [7:0] b1);
`ifdef MULTIPLICATION_MOD_EARLY_EXIT_EN
      int n = 0;
      for (int v = b1; v != 0; v = v / 2) n++;
      if (n == 0) n = 1;
      return 32'(n + 1);
`else
      return 32'(1 + W);
`endif
   endfunction

   // Monitor
   int          hi = 0;
   int          lo = 0;
   bit          prev = 0;
   bit          pend = 0;
   logic [31:0] pexp;
   exp_t        cur;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hi = 0; prev = 0; pend = 0;
         end else begin
            if (pend) begin
               chk("result", {16'h0, mif.Out1, mif.Out2}, pexp);
               pend = 0;
            end
            if (mif.Stall) begin
               if (!prev) begin
                  last_gap = lo;
                  lo = 0;
               end
               hi++;
            end else begin
               if (prev) begin
                  if (sbq.size() == 0) chk("unexpected completion", 1, 0);
                  else begin
                     cur = sbq.pop_front();
                     chk("stall cycles", 32'(hi), cur.ncyc);
                     pexp = cur.res;
                     pend = 1;
                  end
                  hi = 0;
               end
               lo++;
            end
            prev = mif.Stall;
         end
      end
   end

   // Wait (bounded) for the DONE cycle, then move into the following cycle.
   task automatic wait_done(input bit perturb);
      bit seen = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!mif.Stall) begin
            seen = 1;
            break;
         end
         if (perturb && i == 3) begin
            #1;
            mif.A1 = 8'($urandom);
            mif.B1 = 8'($urandom);
            mif.A2 = 8'($urandom);
            mif.B2 = 8'($urandom);
            mif.Op = 4'($urandom);
         end
      end
      if (!seen) chk("stall timeout", 1, 0);
      @(posedge clk);
      #1;
      mif.Op = 4'h0;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after completion.
   task automatic do_op(input logic [3:0] op, input logic [7:0] a1, input logic [7:0] b1,
                        input logic [7:0] a2, input logic [7:0] b2, input bit perturb);
      bit          m = (op == OP_MUL) || (op == OP_MULADD);
      int unsigned add = (op == OP_MULADD) ? {b2, a2} : 0;
      exp_t        e;
      mif.Op = op; mif.A1 = a1; mif.B1 = b1; mif.A2 = a2; mif.B2 = b2;
      if (m) begin
         e.res  = 32'((int'(a1) * int'(b1) + add) % 65536);
         e.ncyc = stall_len(b1);
         sbq.push_back(e);
         last_out = e.res;
         wait_done(perturb);
      end else begin
         @(negedge clk);
         chk("nonmul stall", {31'h0, mif.Stall}, 0);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("nonmul hold", {16'h0, mif.Out1, mif.Out2}, last_out);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   r;
      logic [3:0] op;
      mif.Op = 4'h0; mif.A1 = 0; mif.A2 = 0; mif.B1 = 0; mif.B2 = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset Out1", {24'h0, mif.Out1}, 0);
         chk("reset Out2", {24'h0, mif.Out2}, 0);
         chk("reset Stall", {31'h0, mif.Stall}, 0);
      end
      @(posedge clk);
      #1;

      do_op(OP_MUL,    8'd83,  8'd5,   8'h00, 8'h00, 0);
      do_op(OP_MULADD, 8'd83,  8'd5,   8'h06, 8'h02, 0);
      do_op(OP_MULADD, 8'd255, 8'd255, 8'hFF, 8'hFF, 0);
      do_op(OP_MUL,    8'd255, 8'd255, 8'h00, 8'h00, 0);
      do_op(OP_MUL,    8'd0,   8'd200, 8'h00, 8'h00, 0);
      chk("b2b gap", 32'(last_gap), 1);
      do_op(OP_MUL,    8'h5A,  8'hC3,  8'h00, 8'h00, 1);
      do_op(4'h7,      8'd1,   8'd2,   8'd3,  8'd4,  0);

      // Reset in the middle of BUSY, Op held, then a full restart.
      mif.Op = OP_MUL; mif.A1 = 8'd3; mif.B1 = 8'd7; mif.A2 = 0; mif.B2 = 0;
`ifdef MULTIPLICATION_MOD_EARLY_EXIT_EN
      repeat (2) @(posedge clk);
`else
      repeat (4) @(posedge clk);
`endif
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid-reset Out1", {24'h0, mif.Out1}, 0);
      chk("mid-reset Out2", {24'h0, mif.Out2}, 0);
      e.res = 32'h15; e.ncyc = stall_len(8'd7);
      sbq.push_back(e);
      last_out = 32'h15;
      wait_done(0);

      for (int k = 0; k < 25; k++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: op = OP_MUL;
            1: op = OP_MULADD;
            2: begin
               op = 4'($urandom);
               if (op == OP_MUL || op == OP_MULADD) op = 4'hF;
            end
            default: op = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_MULADD;
         endcase
         do_op(op, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), r == 3);
      end

      repeat (3) @(negedge clk);
      chk("queue empty", 32'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multiplication_mod.md
Name: multiplication_mod

Overview:
- Multicycle shift-add multiplier; the inverse arithmetic unit of the existing divider.
- Shares the divider's operand/result/Stall interface, so the ALU stage can steer either unit.
- Captures operands when a multiply Op arrives and holds Stall until the 16-bit result is ready.
- The result is returned as high byte on Out1 and low byte on Out2.

Parameters:
- WIDTH, 8, operand byte width. Results are 2*WIDTH, split across Out1/Out2.
- OP_MUL, 4'b0010, opcode for unsigned multiply.
- OP_MULADD, 4'b0101, opcode for multiply-add.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- A1  in  WIDTH  multiplicand.
- A2  in  WIDTH  addend low byte (MULADD only).
- B1  in  WIDTH  multiplier.
- B2  in  WIDTH  addend high byte (MULADD only).
- Op  in  4  operation select; only OP_MUL and OP_MULADD are acted on.
- Out1  out  WIDTH  result high byte, registered.
- Out2  out  WIDTH  result low byte, registered.
- Stall  out  1  high while a multiply is pending or in progress.

Behaviour:
- Reset state: state=IDLE, Out1=0, Out2=0, internal accumulator/counter=0. Reset is synchronous and active-high, and wins over all other activity.
- States:
  - IDLE: if Op is OP_MUL or OP_MULADD, latch A1, B1 and addend {B2,A2}, then go to BUSY. Addend is forced to 0 for OP_MUL. Counter=0, acc=0.
  - BUSY: each cycle, if multiplier LSB=1 then acc += multiplicand<<counter. Multiplier shifts right 1 and counter increments. After counter reaches WIDTH-1 (8 BUSY cycles), go to DONE.
  - DONE: {Out1,Out2} <= (acc + addend) mod 2^16, then go to IDLE.
- Stall is combinational: (state==IDLE && Op is a multiply op) || state==BUSY. Stall is low in DONE.
- Latency:
  - Op first presented at edge 0; Stall is high for 9 cycles (IDLE capture cycle plus 8 BUSY).
  - Outputs update at the edge leaving DONE.
  - Upstream holds Op and operands while Stall=1 and advances on the first Stall=0 cycle.
- Back-to-back multiplies: a new multiply Op seen in IDLE after DONE starts a fresh operation. No bubble is needed beyond the DONE cycle.
- Operand/Op changes during BUSY/DONE are ignored; the latched values are used.
- Non-multiply Op in IDLE: Stall=0 and Out1/Out2 hold their previous values.
- Arithmetic: unsigned only; the product fits in 16 bits. MULADD wraps modulo 2^16 and carry-out is discarded.
- Reset mid-operation: aborts and returns to IDLE with outputs 0. If Op is still a multiply Op on the next cycle, Stall re-asserts and the operation restarts from scratch.
- Zero operands take the full latency (without the optional feature) and yield 0 (+ addend).

Optional Feature:
- Macro: MULTIPLICATION_MOD_EARLY_EXIT_EN.
- Defined: BUSY exits to DONE at the end of any cycle where the shifted multiplier register becomes 0. There is a minimum of 1 BUSY cycle; the result is identical. Example: B1=5 (3'b101) gives 3 BUSY cycles, so Stall is high 4 cycles.
- Undefined: always exactly 8 BUSY cycles.

Test Plan:
- Reset with Op=4'b0000 -> Out1=0x00, Out2=0x00, Stall=0; outputs unchanged over 5 cycles.
- Op=OP_MUL, A1=83, B1=5 -> Stall high exactly 9 cycles (4 with EARLY_EXIT), then Out1=0x01, Out2=0x9F (415).
- Op=OP_MULADD, A1=83, B1=5, A2=0x06, B2=0x02 -> {Out1,Out2}=0x03A5 (933). Op=OP_MULADD, A1=B1=255, addend 0xFFFF -> 0xFE00 (wrap).
- Op=OP_MUL, A1=255, B1=255, then A1=0, B1=200 back-to-back -> first result 0xFE01; second starts the cycle after DONE and gives 0x0000. The bench checks the Stall=0 gap is exactly 1 cycle.
- Change A1/B1/Op mid-BUSY -> result still matches the originally latched operands.
- Assert rst on the 4th BUSY cycle with Op held at OP_MUL, A1=3, B1=7 -> outputs 0 the next cycle, then a restart. Result 0x0015 after a full latency from the restart.
